// File: rtl/memory_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : memory_sequencer
//  Description : Block-command initiator for a handshake memory. Turns
//                {write, base, len} commands into consecutive address/data
//                beats on the memory channels and bridges data to and from
//                a pair of stb/rdy streams.
//  Revision    : 1.0 - initial release
// ============================================================================
module memory_sequencer #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 256,
   localparam int A = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,

   input  logic             cmd_stb,
   input  logic [2*A:0]     cmd_dat,
   output logic             cmd_rdy,

   output logic             done_stb,
   input  logic             done_rdy,

   input  logic             sin_stb,
   input  logic [WIDTH-1:0] sin_dat,
   output logic             sin_rdy,

   output logic             sout_stb,
   output logic [WIDTH-1:0] sout_dat,
   input  logic             sout_rdy,

   output logic             waddr_stb,
   output logic [A-1:0]     waddr_dat,
   input  logic             waddr_rdy,

   output logic             wdata_stb,
   output logic [WIDTH-1:0] wdata_dat,
   input  logic             wdata_rdy,

   output logic             raddr_stb,
   output logic [A-1:0]     raddr_dat,
   input  logic             raddr_rdy,

   input  logic             rdata_stb,
   input  logic [WIDTH-1:0] rdata_dat,
   output logic             rdata_rdy
);

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_WRITE = 2'd1;
   localparam logic [1:0] c_READ  = 2'd2;
   localparam logic [1:0] c_DONE  = 2'd3;

   localparam logic [A-1:0] c_ADDR_ONE = A'(1);
   localparam logic [A:0]   c_CNT_ONE  = (A+1)'(1);

   logic [1:0]   r_state;
   logic [1:0]   w_next_state;
   logic [A-1:0] r_addr;
   logic [A:0]   r_issue;    // words still to be issued to the memory
   logic [A:0]   r_recv;     // words still to be returned on sout

   logic         w_cmd_write;
   logic [A-1:0] w_cmd_base;
   logic [A-1:0] w_cmd_len;
   logic [A:0]   w_cmd_words;

   logic         w_cmd_fire;
   logic         w_wr_fire;
   logic         w_ra_fire;
   logic         w_rd_fire;

   assign w_cmd_write = cmd_dat[2*A];
   assign w_cmd_base  = cmd_dat[2*A-1:A];
   assign w_cmd_len   = cmd_dat[A-1:0];
   assign w_cmd_words = {1'b0, w_cmd_len} + c_CNT_ONE;

   assign w_cmd_fire = cmd_stb & cmd_rdy;
   assign w_wr_fire  = wdata_stb & wdata_rdy;
   assign w_ra_fire  = raddr_stb & raddr_rdy;
   assign w_rd_fire  = sout_stb & sout_rdy;

   // State register; reset abandons any command in progress.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= c_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Address and word counters: loaded on command, stepped per handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_addr  <= '0;
         r_issue <= '0;
         r_recv  <= '0;
      end else begin
         case (r_state)
            c_IDLE: begin
               if (w_cmd_fire) begin
                  r_addr  <= w_cmd_base;
                  r_issue <= w_cmd_words;
                  r_recv  <= w_cmd_words;
               end
            end
            c_WRITE: begin
               if (w_wr_fire) begin
                  r_addr  <= r_addr + c_ADDR_ONE;
                  r_issue <= r_issue - c_CNT_ONE;
               end
            end
            c_READ: begin
               if (w_ra_fire) begin
                  r_addr  <= r_addr + c_ADDR_ONE;
                  r_issue <= r_issue - c_CNT_ONE;
               end
               if (w_rd_fire) begin
                  r_recv <= r_recv - c_CNT_ONE;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Next state: leave WRITE/READ on the final decrement so counters never wrap.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_IDLE: begin
            if (w_cmd_fire) begin
               w_next_state = w_cmd_write ? c_WRITE : c_READ;
            end
         end
         c_WRITE: begin
            if (w_wr_fire && (r_issue == c_CNT_ONE)) begin
               w_next_state = c_DONE;
            end
         end
         c_READ: begin
            if (w_rd_fire && (r_recv == c_CNT_ONE)) begin
               w_next_state = c_DONE;
            end
         end
         default: begin
            if (done_rdy) begin
               w_next_state = c_IDLE;
            end
         end
      endcase
   end

   // Channel outputs; strobes depend only on state and upstream strobes, never on readies.
   always_comb begin
      cmd_rdy   = 1'b0;
      done_stb  = 1'b0;
      sin_rdy   = 1'b0;
      sout_stb  = 1'b0;
      sout_dat  = rdata_dat;
      waddr_stb = 1'b0;
      waddr_dat = r_addr;
      wdata_stb = 1'b0;
      wdata_dat = sin_dat;
      raddr_stb = 1'b0;
      raddr_dat = r_addr;
      rdata_rdy = 1'b1;   // outside READ any leftover memory word is drained
      case (r_state)
         c_IDLE: begin
            cmd_rdy = 1'b1;
         end
         c_WRITE: begin
            waddr_stb = 1'b1;
            wdata_stb = sin_stb;
            sin_rdy   = wdata_rdy;
         end
         c_READ: begin
            raddr_stb = (r_issue != '0);
            sout_stb  = rdata_stb;
            rdata_rdy = sout_rdy;
         end
         default: begin
            done_stb = 1'b1;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_memory_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_memory_sequencer
//  Description : Bench for memory_sequencer with a registered-read memory
//                model and a command-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_sequencer;

   localparam int WIDTH = 16;
   localparam int DEPTH = 256;
   localparam int A     = 8;

   localparam int P_IDLE = 0;
   localparam int P_WR   = 1;
   localparam int P_RD   = 2;
   localparam int P_DONE = 3;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             cmd_stb = 1'b0;
   logic [2*A:0]     cmd_dat = '0;
   logic             cmd_rdy;
   logic             done_stb;
   logic             done_rdy = 1'b1;
   logic             sin_stb = 1'b0;
   logic [WIDTH-1:0] sin_dat = '0;
   logic             sin_rdy;
   logic             sout_stb;
   logic [WIDTH-1:0] sout_dat;
   logic             sout_rdy = 1'b1;
   logic             waddr_stb;
   logic [A-1:0]     waddr_dat;
   logic             waddr_rdy;
   logic             wdata_stb;
   logic [WIDTH-1:0] wdata_dat;
   logic             wdata_rdy;
   logic             raddr_stb;
   logic [A-1:0]     raddr_dat;
   logic             raddr_rdy;
   logic             rdata_stb;
   logic [WIDTH-1:0] rdata_dat;
   logic             rdata_rdy;

   memory_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .cmd_stb(cmd_stb), .cmd_dat(cmd_dat), .cmd_rdy(cmd_rdy),
      .done_stb(done_stb), .done_rdy(done_rdy),
      .sin_stb(sin_stb), .sin_dat(sin_dat), .sin_rdy(sin_rdy),
      .sout_stb(sout_stb), .sout_dat(sout_dat), .sout_rdy(sout_rdy),
      .waddr_stb(waddr_stb), .waddr_dat(waddr_dat), .waddr_rdy(waddr_rdy),
      .wdata_stb(wdata_stb), .wdata_dat(wdata_dat), .wdata_rdy(wdata_rdy),
      .raddr_stb(raddr_stb), .raddr_dat(raddr_dat), .raddr_rdy(raddr_rdy),
      .rdata_stb(rdata_stb), .rdata_dat(rdata_dat), .rdata_rdy(rdata_rdy)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
      n_chk++;
      if (!ok) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- memory model: registered read, always-ready write ----
   logic             wr_ready = 1'b1;
   logic [WIDTH-1:0] mem [DEPTH];
   bit               mem_inited = 1'b0;
   logic             rvalid = 1'b0;
   logic [WIDTH-1:0] rdat = '0;

   assign waddr_rdy = wr_ready;
   assign wdata_rdy = wr_ready;
   assign raddr_rdy = !rvalid || rdata_rdy;
   assign rdata_stb = rvalid;
   assign rdata_dat = rdat;

   always @(posedge clk) begin
      if (!mem_inited) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= WIDTH'(16'h5000 + i);
         mem_inited <= 1'b1;
      end else begin
         if (waddr_stb && waddr_rdy && wdata_stb && wdata_rdy) mem[waddr_dat] <= wdata_dat;
         if (raddr_stb && raddr_rdy) begin
            rvalid <= 1'b1;
            rdat   <= mem[raddr_dat];
         end else if (rdata_rdy) begin
            rvalid <= 1'b0;
         end
      end
   end

   // ---------------- stimulus driver -------------------------------------
   int               cyc = 0;
   int               pat = 0;
   int               sout_mode = 0;  // 0 always, 1 random, 2 pattern 1,0,0, 3 never
   bit               rand_wr = 1'b0;
   bit               rand_gap = 1'b0;
   bit               rand_done = 1'b0;
   logic [WIDTH-1:0] sin_q[$];

   always @(posedge clk) begin
      cyc = cyc + 1;
      #1;
      pat = pat + 1;
      wr_ready = rand_wr ? ($urandom_range(0, 3) != 0) : 1'b1;
      case (sout_mode)
         0:       sout_rdy = 1'b1;
         1:       sout_rdy = 1'($urandom_range(0, 1));
         2:       sout_rdy = (pat % 3 == 0);
         default: sout_rdy = 1'b0;
      endcase
      done_rdy = rand_done ? 1'($urandom_range(0, 1)) : 1'b1;
      if (sin_q.size() > 0) begin
         sin_stb = rand_gap ? ($urandom_range(0, 2) != 0) : 1'b1;
         sin_dat = sin_q[0];
      end else begin
         sin_stb = 1'b0;
         sin_dat = WIDTH'($urandom);
      end
   end

   // ---------------- reference model and per-cycle compare ---------------
   int               m_phase = P_IDLE;
   int               m_base = 0, m_n = 0, m_iss = 0, m_rcv = 0, m_wr = 0;
   logic [WIDTH-1:0] refmem [DEPTH];
   bit               ref_inited = 1'b0;

   always @(negedge clk) begin
      if (!ref_inited) begin
         for (int i = 0; i < DEPTH; i++) refmem[i] = WIDTH'(16'h5000 + i);
         ref_inited = 1'b1;
      end
      if (rst) begin
         m_phase = P_IDLE;
      end else begin
         chk(cmd_rdy === (m_phase == P_IDLE), "cmd_rdy", cmd_rdy, m_phase == P_IDLE);
         chk(done_stb === (m_phase == P_DONE), "done_stb", done_stb, m_phase == P_DONE);
         chk(waddr_stb === (m_phase == P_WR), "waddr_stb", waddr_stb, m_phase == P_WR);
         chk(wdata_stb === (m_phase == P_WR && sin_stb), "wdata_stb", wdata_stb, m_phase == P_WR && sin_stb);
         chk(sin_rdy === (m_phase == P_WR && wr_ready), "sin_rdy", sin_rdy, m_phase == P_WR && wr_ready);
         chk(raddr_stb === (m_phase == P_RD && m_iss < m_n), "raddr_stb", raddr_stb, m_phase == P_RD && m_iss < m_n);
         chk(sout_stb === (m_phase == P_RD && rdata_stb), "sout_stb", sout_stb, m_phase == P_RD && rdata_stb);
         chk(rdata_rdy === ((m_phase == P_RD) ? sout_rdy : 1'b1), "rdata_rdy", rdata_rdy,
             (m_phase == P_RD) ? sout_rdy : 1'b1);
         case (m_phase)
            P_IDLE: begin
               if (cmd_stb) begin
                  m_phase = cmd_dat[2*A] ? P_WR : P_RD;
                  m_base  = int'(cmd_dat[2*A-1:A]);
                  m_n     = int'(cmd_dat[A-1:0]) + 1;
                  m_iss   = 0;
                  m_rcv   = 0;
                  m_wr    = 0;
               end
            end
            P_WR: begin
               chk(waddr_dat == A'((m_base + m_wr) % DEPTH), "waddr_dat", waddr_dat, (m_base + m_wr) % DEPTH);
               if (sin_stb) chk(wdata_dat === sin_dat, "wdata_dat", wdata_dat, sin_dat);
               if (sin_stb && wr_ready && sin_q.size() > 0) begin
                  refmem[(m_base + m_wr) % DEPTH] = sin_q[0];
                  void'(sin_q.pop_front());
                  m_wr++;
                  if (m_wr == m_n) m_phase = P_DONE;
               end
            end
            P_RD: begin
               if (raddr_stb) chk(raddr_dat == A'((m_base + m_iss) % DEPTH), "raddr_dat", raddr_dat,
                                  (m_base + m_iss) % DEPTH);
               if (raddr_stb && raddr_rdy && m_iss < m_n) m_iss++;
               if (rdata_stb && sout_rdy) begin
                  chk(sout_dat === refmem[(m_base + m_rcv) % DEPTH], "sout_dat", sout_dat,
                      refmem[(m_base + m_rcv) % DEPTH]);
                  m_rcv++;
                  if (m_rcv == m_n) m_phase = P_DONE;
               end
            end
            default: begin
               if (done_rdy) m_phase = P_IDLE;
            end
         endcase
      end
   end

   // ---------------- observation of DUT timing for literal checks --------
   int               mon_cmd_cyc = -1, mon_done_cyc = -1, mon_sout_cyc = -1;
   int               mon_xfers = 0, mon_last_xfer_cyc = -1;
   logic [WIDTH-1:0] mon_last_sout = '0;

   always @(negedge clk) begin
      if (!rst) begin
         if (cmd_stb && cmd_rdy) begin
            mon_cmd_cyc = cyc; mon_done_cyc = -1; mon_sout_cyc = -1;
            mon_xfers = 0; mon_last_xfer_cyc = -1;
         end
         if (done_stb && mon_done_cyc < 0) mon_done_cyc = cyc;
         if (sout_stb && mon_sout_cyc < 0) mon_sout_cyc = cyc;
         if ((sin_stb && sin_rdy) || (sout_stb && sout_rdy)) begin
            mon_xfers++;
            mon_last_xfer_cyc = cyc;
            if (sout_stb) mon_last_sout = sout_dat;
         end
      end
   end

   // ---------------- command sequencing ----------------------------------
   task automatic pulse_reset(input int n);
      @(posedge clk); #2;
      rst = 1'b1;
      sin_q.delete();
      repeat (n) @(posedge clk);
      #2 rst = 1'b0;
   endtask

   task automatic issue_cmd(input bit wr, input int base, input int len, output bit ok);
      @(posedge clk); #2;
      cmd_stb = 1'b1;
      cmd_dat = {wr, A'(base), A'(len)};
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk); #1;
         if (cmd_rdy) ok = 1'b1;
      end
      @(posedge clk); #2;
      cmd_stb = 1'b0;
      chk(ok, "cmd_accept_timeout", ok, 1);
   endtask

   task automatic run_cmd(input bit wr, input int base, input int len);
      bit ok;
      bit got;
      issue_cmd(wr, base, len, ok);
      got = 1'b0;
      if (ok) begin
         for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk); #1;
            if (done_stb && done_rdy) got = 1'b1;
         end
      end
      chk(got, "done_timeout", got, 1);
      if (got) begin
         chk(mon_xfers == len + 1, "xfer_count", mon_xfers, len + 1);
         chk(mon_done_cyc == mon_last_xfer_cyc + 1, "done_after_last", mon_done_cyc, mon_last_xfer_cyc + 1);
      end else begin
         pulse_reset(2);
      end
   endtask

   initial begin
      bit ok;
      int wr, base, len;

      // reset values
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk(cmd_rdy === 1'b1, "rst_cmd_rdy", cmd_rdy, 1);
      chk(done_stb === 1'b0, "rst_done_stb", done_stb, 0);
      chk(waddr_stb === 1'b0, "rst_waddr_stb", waddr_stb, 0);
      chk(wdata_stb === 1'b0, "rst_wdata_stb", wdata_stb, 0);
      chk(raddr_stb === 1'b0, "rst_raddr_stb", raddr_stb, 0);
      chk(sout_stb === 1'b0, "rst_sout_stb", sout_stb, 0);
      chk(sin_rdy === 1'b0, "rst_sin_rdy", sin_rdy, 0);
      chk(rdata_rdy === 1'b1, "rst_rdata_rdy", rdata_rdy, 1);
      @(posedge clk); #2 rst = 1'b0;

      // 4-word write, back-to-back
      for (int i = 0; i < 4; i++) sin_q.push_back(WIDTH'(16'hA000 + i));
      run_cmd(1'b1, 8'h10, 3);
      chk(mon_done_cyc - mon_cmd_cyc == 5, "wr4_done_latency", mon_done_cyc - mon_cmd_cyc, 5);
      for (int i = 0; i < 4; i++) chk(mem[8'h10 + i] == WIDTH'(16'hA000 + i), "wr4_mem", mem[8'h10 + i], 16'hA000 + i);

      // 4-word read
      run_cmd(1'b0, 8'h10, 3);
      chk(mon_sout_cyc - mon_cmd_cyc == 2, "rd4_first_sout", mon_sout_cyc - mon_cmd_cyc, 2);
      chk(mon_done_cyc - mon_cmd_cyc == 6, "rd4_done_latency", mon_done_cyc - mon_cmd_cyc, 6);
      chk(mon_last_sout == 16'hA003, "rd4_last_word", mon_last_sout, 16'hA003);

      // single-word write: cmd@0, write@1, done@2
      sin_q.push_back(16'h1234);
      run_cmd(1'b1, 8'h80, 0);
      chk(mon_done_cyc - mon_cmd_cyc == 2, "wr1_done_latency", mon_done_cyc - mon_cmd_cyc, 2);

      // reset in the middle of a 4-word read
      issue_cmd(1'b0, 8'h10, 3, ok);
      for (int i = 0; i < 20 && mon_xfers < 2; i++) begin
         @(negedge clk); #1;
      end
      chk(mon_xfers == 2, "rstmid_progress", mon_xfers, 2);
      sout_mode = 3;
      @(posedge clk); #2 rst = 1'b1;
      @(posedge clk); #2 rst = 1'b0;
      sout_mode = 0;
      @(negedge clk);
      chk({waddr_stb, wdata_stb, raddr_stb, sout_stb, done_stb} === 5'b0, "rstmid_stbs",
          {waddr_stb, wdata_stb, raddr_stb, sout_stb, done_stb}, 0);
      chk(cmd_rdy === 1'b1, "rstmid_cmd_rdy", cmd_rdy, 1);
      run_cmd(1'b0, 8'h13, 0);
      chk(mon_last_sout == 16'hA003, "rstmid_reread", mon_last_sout, 16'hA003);

      // address wrap
      for (int i = 0; i < 3; i++) sin_q.push_back(WIDTH'(16'hC000 + i));
      run_cmd(1'b1, 8'hFE, 2);
      run_cmd(1'b0, 8'hFE, 2);
      chk(mon_last_sout == 16'hC002, "wrap_last_word", mon_last_sout, 16'hC002);
      chk(mem[8'h00] == 16'hC002, "wrap_mem0", mem[8'h00], 16'hC002);
      chk(mem[8'h01] == 16'h5001, "wrap_mem1_untouched", mem[8'h01], 16'h5001);

      // backpressure: gapped write, 1,0,0 read ready
      rand_gap = 1'b1;
      for (int i = 0; i < 8; i++) sin_q.push_back(WIDTH'(16'hB000 + i));
      run_cmd(1'b1, 8'h40, 7);
      rand_gap = 1'b0;
      sout_mode = 2;
      run_cmd(1'b0, 8'h40, 7);
      sout_mode = 0;
      chk(mon_last_sout == 16'hB007, "bp_last_word", mon_last_sout, 16'hB007);

      // full sweep
      for (int i = 0; i < DEPTH; i++) sin_q.push_back(WIDTH'(i));
      run_cmd(1'b1, 0, DEPTH - 1);
      chk(mon_done_cyc - mon_cmd_cyc == DEPTH + 1, "sweep_wr_latency", mon_done_cyc - mon_cmd_cyc, DEPTH + 1);
      run_cmd(1'b0, 0, DEPTH - 1);
      chk(mon_done_cyc - mon_cmd_cyc == DEPTH + 2, "sweep_rd_latency", mon_done_cyc - mon_cmd_cyc, DEPTH + 2);
      chk(mon_last_sout == 16'h00FF, "sweep_last_word", mon_last_sout, 16'h00FF);

      // randomized commands under random backpressure
      for (int k = 0; k < 25; k++) begin
         wr        = int'($urandom_range(0, 1));
         base      = int'($urandom_range(0, DEPTH - 1));
         len       = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, DEPTH - 1)) : int'($urandom_range(0, 15));
         rand_wr   = 1'($urandom_range(0, 1));
         rand_gap  = 1'($urandom_range(0, 1));
         rand_done = 1'($urandom_range(0, 1));
         sout_mode = int'($urandom_range(0, 2));
         if (wr != 0) for (int i = 0; i <= len; i++) sin_q.push_back(WIDTH'($urandom));
         run_cmd(wr != 0, base, len);
      end

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
